// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// Request, completion and memory-side signals of the memory port arbiter.
// slave: the arbiter itself; master: the requesters plus the memory macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ack;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_ack;
    logic [DATA_W-1:0] l_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        input  mem_rdata,
        output c_ack, c_rdata, l_ack, l_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output grant, busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        output mem_rdata,
        input  c_ack, c_rdata, l_ack, l_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  grant, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares the single-port program/data memory between the CPU controller
// (port C) and the program loader/debug port (port L).
module mem_port_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t            state;
    logic              win_l;
    logic              last_l;
    logic              lock_flag;
    logic [2:0]        cnt;
    logic              pick_l;
    logic              pick_c;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Winner for this IDLE cycle: held lock, then sole requester, then
    // the port that did not own the previous access.
    always_comb begin
        pick_l    = bus.l_req & (lock_flag | ~bus.c_req | ~last_l);
        pick_c    = bus.c_req & ~pick_l;
        sel_we    = pick_l ? bus.l_we    : bus.c_we;
        sel_addr  = pick_l ? bus.l_addr  : bus.c_addr;
        sel_wdata = pick_l ? bus.l_wdata : bus.c_wdata;
    end

    // Access sequencer; every output is a register driven from here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            win_l         <= 1'b0;
            last_l        <= 1'b1;
            lock_flag     <= 1'b0;
            cnt           <= '0;
            bus.c_ack     <= 1'b0;
            bus.l_ack     <= 1'b0;
            bus.c_rdata   <= '0;
            bus.l_rdata   <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.grant     <= 2'b00;
            bus.busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.l_req) begin
                        lock_flag <= 1'b0;
                    end
                    if (pick_l | pick_c) begin
                        win_l         <= pick_l;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_we    <= sel_we;
                        bus.mem_re    <= ~sel_we;
                        bus.grant     <= pick_l ? 2'b10 : 2'b01;
                        bus.busy      <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.mem_we <= 1'b0;
                    bus.mem_re <= 1'b0;
                    if (bus.mem_we) begin
                        bus.c_ack <= ~win_l;
                        bus.l_ack <= win_l;
                        state     <= ACK;
                    end else begin
                        cnt   <= 3'(READ_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        if (win_l) begin
                            bus.l_rdata <= bus.mem_rdata;
                        end else begin
                            bus.c_rdata <= bus.mem_rdata;
                        end
                        bus.c_ack <= ~win_l;
                        bus.l_ack <= win_l;
                        state     <= ACK;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACK: begin
                    bus.c_ack <= 1'b0;
                    bus.l_ack <= 1'b0;
                    bus.grant <= 2'b00;
                    bus.busy  <= 1'b0;
                    last_l    <= win_l;
                    lock_flag <= win_l & bus.l_lock;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: four instances with READ_LAT 1..4, each
// with its own memory model, driven from shared per-lane signal arrays.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0]       rst_v;
    logic [3:0]       c_req_v, c_we_v, l_req_v, l_we_v, l_lock_v;
    logic [3:0][12:0] c_addr_v, l_addr_v;
    logic [3:0][7:0]  c_wdata_v, l_wdata_v;
    logic [3:0]       c_ack_v, l_ack_v, mem_we_v, mem_re_v, busy_v;
    logic [3:0][7:0]  c_rdata_v, l_rdata_v, mem_wdata_v, mem_rdata_v;
    logic [3:0][12:0] mem_addr_v;
    logic [3:0][1:0]  grant_v;

    for (genvar g = 0; g < 4; g++) begin : lane
        mem_port_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();
        logic [7:0] mem [8192];
        logic [7:0] pipe [4];
        logic       inited = 1'b0;

        assign bus.c_req     = c_req_v[g];
        assign bus.c_we      = c_we_v[g];
        assign bus.c_addr    = c_addr_v[g];
        assign bus.c_wdata   = c_wdata_v[g];
        assign bus.l_req     = l_req_v[g];
        assign bus.l_we      = l_we_v[g];
        assign bus.l_addr    = l_addr_v[g];
        assign bus.l_wdata   = l_wdata_v[g];
        assign bus.l_lock    = l_lock_v[g];
        assign bus.mem_rdata = pipe[g];
        assign mem_rdata_v[g] = pipe[g];
        assign c_ack_v[g]     = bus.c_ack;
        assign l_ack_v[g]     = bus.l_ack;
        assign c_rdata_v[g]   = bus.c_rdata;
        assign l_rdata_v[g]   = bus.l_rdata;
        assign mem_addr_v[g]  = bus.mem_addr;
        assign mem_wdata_v[g] = bus.mem_wdata;
        assign mem_we_v[g]    = bus.mem_we;
        assign mem_re_v[g]    = bus.mem_re;
        assign grant_v[g]     = bus.grant;
        assign busy_v[g]      = bus.busy;

        mem_port_arbiter #(
            .ADDR_W(13), .DATA_W(8), .READ_LAT(g + 1)
        ) dut (
            .clk(clk),
            .rst(rst_v[g]),
            .bus(bus)
        );

        // Memory macro: data appears READ_LAT cycles after mem_re,
        // junk (0xEE) in every other cycle.
        always @(posedge clk) begin
            if (!inited) begin
                for (int i = 0; i < 8192; i++) mem[i] <= 8'(i) ^ 8'h33;
                inited <= 1'b1;
            end else if (mem_we_v[g] === 1'b1) begin
                mem[mem_addr_v[g]] <= mem_wdata_v[g];
            end
            pipe[0] <= (mem_re_v[g] === 1'b1) ? mem[mem_addr_v[g]] : 8'hEE;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end

        // Read and write strobes must never overlap.
        always @(negedge clk) begin
            if (!$isunknown({mem_we_v[g], mem_re_v[g]})) begin
                checks++;
                if (mem_we_v[g] && mem_re_v[g]) begin
                    errors++;
                    $display("FAIL strobe_overlap lane %0d: we=1 re=1, required not both", g);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // who: 1 CPU ack, 2 loader ack, 3 both; k: cycles from first request cycle.
    task automatic wait_ack(input int ln, output int who, output int k);
        who = 0;
        k = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (c_ack_v[ln] === 1'b1 || l_ack_v[ln] === 1'b1) begin
                who = int'({l_ack_v[ln] === 1'b1, c_ack_v[ln] === 1'b1});
                k = i;
                break;
            end
        end
        if (who == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout lane %0d: no ack in 40 cycles", ln);
        end
    endtask

    task automatic do_single(input int ln, input bit port_l, input bit we,
                             input logic [12:0] addr, input logic [7:0] wdata,
                             output int who, output int k, output logic [7:0] rd);
        if (port_l) begin
            l_req_v[ln] = 1'b1; l_we_v[ln] = we;
            l_addr_v[ln] = addr; l_wdata_v[ln] = wdata;
        end else begin
            c_req_v[ln] = 1'b1; c_we_v[ln] = we;
            c_addr_v[ln] = addr; c_wdata_v[ln] = wdata;
        end
        wait_ack(ln, who, k);
        rd = port_l ? l_rdata_v[ln] : c_rdata_v[ln];
        @(posedge clk); #1;
        c_req_v[ln] = 1'b0;
        l_req_v[ln] = 1'b0;
    endtask

    task automatic lane_reset(input int ln);
        @(posedge clk); #1;
        rst_v[ln] = 1'b0;
        c_req_v[ln] = 1'b0;
        l_req_v[ln] = 1'b0;
        l_lock_v[ln] = 1'b0;
        @(posedge clk); #1;
        rst_v[ln] = 1'b1;
    endtask

    // Random traffic on one lane against a transaction-timing model:
    // a grant at cycle t acks at t+2 (write) or t+2+lat (read) and the
    // arbiter takes the next decision the cycle after the ack.
    task automatic run_random(input int ln, input int ncyc);
        int lat;
        logic [7:0] rm [16];
        bit active, own_l, own_we, last_l, lock, take_l, take_c, on, st;
        bit c_pend, l_pend, c_seen, l_seen;
        logic [12:0] own_a;
        logic [7:0] own_d, crd, lrd;
        int g_cyc, a_cyc, free_at;
        lat = ln + 1;
        for (int i = 0; i < 16; i++) rm[i] = 8'(i) ^ 8'h33;
        active = 0; own_l = 0; own_we = 0; last_l = 1; lock = 0;
        c_pend = 0; l_pend = 0; c_seen = 0; l_seen = 0;
        own_a = '0; own_d = '0; crd = '0; lrd = '0;
        g_cyc = -10; a_cyc = -10; free_at = 0;
        lane_reset(ln);
        for (int n = 0; n < ncyc; n++) begin
            if (c_seen) begin c_pend = 0; c_req_v[ln] = 1'b0; end
            if (l_seen) begin l_pend = 0; l_req_v[ln] = 1'b0; end
            if (!c_pend && $urandom_range(0, 2) != 0) begin
                c_pend = 1; c_req_v[ln] = 1'b1;
                c_we_v[ln] = 1'($urandom_range(0, 1));
                c_addr_v[ln] = 13'h100 | 13'($urandom_range(0, 15));
                c_wdata_v[ln] = 8'($urandom);
            end
            if (!l_pend && $urandom_range(0, 2) != 0) begin
                l_pend = 1; l_req_v[ln] = 1'b1;
                l_we_v[ln] = 1'($urandom_range(0, 1));
                l_addr_v[ln] = 13'h100 | 13'($urandom_range(0, 15));
                l_wdata_v[ln] = 8'($urandom);
                l_lock_v[ln] = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            c_seen = (c_ack_v[ln] === 1'b1);
            l_seen = (l_ack_v[ln] === 1'b1);
            if (active && n == a_cyc) begin
                if (!own_we && own_l) lrd = own_d;
                if (!own_we && !own_l) crd = own_d;
                last_l = own_l;
                lock = own_l && l_lock_v[ln];
            end
            on = active && n > g_cyc && n <= a_cyc;
            st = active && n == g_cyc + 1;
            chk("rnd_grant", 32'(grant_v[ln]), on ? (own_l ? 32'd2 : 32'd1) : 32'd0);
            chk("rnd_busy", 32'(busy_v[ln]), 32'(on));
            chk("rnd_c_ack", 32'(c_ack_v[ln]), 32'(active && n == a_cyc && !own_l));
            chk("rnd_l_ack", 32'(l_ack_v[ln]), 32'(active && n == a_cyc && own_l));
            chk("rnd_c_rdata", 32'(c_rdata_v[ln]), 32'(crd));
            chk("rnd_l_rdata", 32'(l_rdata_v[ln]), 32'(lrd));
            chk("rnd_mem_we", 32'(mem_we_v[ln]), 32'(st && own_we));
            chk("rnd_mem_re", 32'(mem_re_v[ln]), 32'(st && !own_we));
            if (st) chk("rnd_mem_addr", 32'(mem_addr_v[ln]), 32'(own_a));
            if (st && own_we) chk("rnd_mem_wdata", 32'(mem_wdata_v[ln]), 32'(own_d));
            if (n >= free_at) begin
                active = 0;
                if (!l_req_v[ln]) lock = 0;
                take_l = 0;
                if (l_req_v[ln] && lock) take_l = 1;
                else if (l_req_v[ln] && !c_req_v[ln]) take_l = 1;
                else if (l_req_v[ln] && c_req_v[ln] && !last_l) take_l = 1;
                take_c = c_req_v[ln] && !take_l;
                if (take_l || take_c) begin
                    active = 1;
                    own_l = take_l;
                    own_we = take_l ? l_we_v[ln] : c_we_v[ln];
                    own_a = take_l ? l_addr_v[ln] : c_addr_v[ln];
                    own_d = take_l ? l_wdata_v[ln] : c_wdata_v[ln];
                    if (own_we) rm[own_a[3:0]] = own_d;
                    else own_d = rm[own_a[3:0]];
                    g_cyc = n;
                    a_cyc = n + (own_we ? 2 : 2 + lat);
                    free_at = a_cyc + 1;
                end
            end
            @(posedge clk); #1;
        end
        c_req_v[ln] = 1'b0;
        l_req_v[ln] = 1'b0;
    endtask

    typedef struct {
        bit          port_l;
        bit          we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        int          lat;
        logic [7:0]  rd;
    } vec_t;

    initial begin
        vec_t tbl [9];
        int who, k, nl;
        logic [7:0] rd;
        int ord_c [6];
        int ord_l [6];

        tbl[0] = '{1'b0, 1'b1, 13'h005,  8'hA7, 2, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 13'h005,  8'h00, 3, 8'hA7};
        tbl[2] = '{1'b1, 1'b1, 13'h010,  8'h3C, 2, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 13'h010,  8'h00, 3, 8'h3C};
        tbl[4] = '{1'b0, 1'b0, 13'h010,  8'h00, 3, 8'h3C};
        tbl[5] = '{1'b1, 1'b0, 13'h005,  8'h00, 3, 8'hA7};
        tbl[6] = '{1'b0, 1'b1, 13'h1FFF, 8'h81, 2, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 3, 8'h81};
        tbl[8] = '{1'b0, 1'b0, 13'h020,  8'h00, 3, 8'h13};
        ord_c = '{1, 2, 1, 2, 1, 2};
        ord_l = '{2, 2, 2, 2, 1, 2};

        rst_v = 4'h0;
        c_req_v = '0; c_we_v = '0; c_addr_v = '0; c_wdata_v = '0;
        l_req_v = '0; l_we_v = '0; l_addr_v = '0; l_wdata_v = '0;
        l_lock_v = '0;

        // Reset holds everything at zero even with a request pending.
        c_req_v[0] = 1'b1; c_we_v[0] = 1'b1;
        c_addr_v[0] = 13'h01F; c_wdata_v[0] = 8'h11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_acks", 32'({c_ack_v[0], l_ack_v[0]}), 32'd0);
        chk("rst_strobes", 32'({mem_we_v[0], mem_re_v[0]}), 32'd0);
        chk("rst_grant_busy", 32'({grant_v[0], busy_v[0]}), 32'd0);
        chk("rst_rdata", 32'({c_rdata_v[0], l_rdata_v[0]}), 32'd0);
        chk("rst_mem_bus", 32'({mem_addr_v[0], mem_wdata_v[0]}), 32'd0);
        @(posedge clk); #1;
        rst_v = 4'hF;
        wait_ack(0, who, k);
        chk("rst_first_port", 32'(who), 32'd1);
        chk("rst_first_lat", 32'(k), 32'd2);
        @(posedge clk); #1;
        c_req_v[0] = 1'b0;

        // Single-port transactions, READ_LAT=1.
        for (int i = 0; i < 9; i++) begin
            do_single(0, tbl[i].port_l, tbl[i].we, tbl[i].addr, tbl[i].wdata, who, k, rd);
            chk($sformatf("vec%0d_port", i), 32'(who), tbl[i].port_l ? 32'd2 : 32'd1);
            chk($sformatf("vec%0d_lat", i), 32'(k), 32'(tbl[i].lat));
            if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
        end

        // Contention from reset: strict alternation, CPU first.
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_v[0] = 1'b1;
        c_req_v[0] = 1'b1; c_we_v[0] = 1'b1; c_addr_v[0] = 13'h030; c_wdata_v[0] = 8'h01;
        l_req_v[0] = 1'b1; l_we_v[0] = 1'b1; l_addr_v[0] = 13'h031; l_wdata_v[0] = 8'h02;
        for (int i = 0; i < 6; i++) begin
            wait_ack(0, who, k);
            chk($sformatf("rr%0d_port", i), 32'(who), 32'(ord_c[i]));
            chk($sformatf("rr%0d_grant", i), 32'(grant_v[0]), 32'(ord_c[i]));
        end
        @(posedge clk); #1;
        c_req_v[0] = 1'b0;
        l_req_v[0] = 1'b0;

        // Loader lock: four locked writes, then the CPU gets in.
        lane_reset(0);
        l_req_v[0] = 1'b1; l_we_v[0] = 1'b1; l_lock_v[0] = 1'b1;
        l_addr_v[0] = 13'h000; l_wdata_v[0] = 8'hD0;
        @(posedge clk); #1;
        c_req_v[0] = 1'b1; c_we_v[0] = 1'b1; c_addr_v[0] = 13'h080; c_wdata_v[0] = 8'h99;
        nl = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ack(0, who, k);
            chk($sformatf("lock%0d_port", i), 32'(who), 32'(ord_l[i]));
            @(posedge clk); #1;
            if (who == 2) begin
                nl++;
                l_addr_v[0] = 13'(nl);
                l_wdata_v[0] = 8'hD0 + 8'(nl);
                l_lock_v[0] = (nl < 3);
            end
        end
        c_req_v[0] = 1'b0;
        l_req_v[0] = 1'b0;
        l_lock_v[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        do_single(0, 1'b0, 1'b0, 13'h002, 8'h00, who, k, rd);
        chk("lock_data", 32'(rd), 32'hD2);

        // Latency sweep over READ_LAT 1..4.
        for (int ln = 0; ln < 4; ln++) begin
            do_single(ln, 1'b1, 1'b1, 13'h040, 8'h60 + 8'(ln), who, k, rd);
            chk($sformatf("sweep%0d_wlat", ln), 32'(k), 32'd2);
            do_single(ln, 1'b0, 1'b0, 13'h040, 8'h00, who, k, rd);
            chk($sformatf("sweep%0d_rlat", ln), 32'(k), 32'(3 + ln));
            chk($sformatf("sweep%0d_rdata", ln), 32'(rd), 32'h60 + 32'(ln));
        end

        // Reset in the middle of a READ_LAT=4 read.
        c_req_v[3] = 1'b1; c_we_v[3] = 1'b0; c_addr_v[3] = 13'h040;
        @(negedge clk);
        @(negedge clk);
        chk("mid_re", 32'(mem_re_v[3]), 32'd1);
        @(negedge clk);
        chk("mid_busy", 32'(busy_v[3]), 32'd1);
        @(posedge clk); #1;
        rst_v[3] = 1'b0;
        c_req_v[3] = 1'b0;
        @(negedge clk);
        chk("mid_no_ack0", 32'(c_ack_v[3]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_idle", 32'({grant_v[3], busy_v[3]}), 32'd0);
        chk("mid_rdata_clr", 32'(c_rdata_v[3]), 32'd0);
        @(posedge clk); #1;
        rst_v[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_ack", 32'(c_ack_v[3]), 32'd0);
        end
        @(posedge clk); #1;
        do_single(3, 1'b0, 1'b0, 13'h040, 8'h00, who, k, rd);
        chk("mid_reissue_lat", 32'(k), 32'd6);
        chk("mid_reissue_rdata", 32'(rd), 32'h63);

        // Random traffic per READ_LAT.
        for (int ln = 0; ln < 4; ln++) run_random(ln, 600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
